aes_wb_regs: RTL and testbench

//  Wishbone B4 classic slave that responds to the management SoC (the bus initiator) for the AES user project.

---
 rtl/aes_wb_regs.sv | 176 +++++++++++++++++
 tb/tb_aes_wb_regs.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_wb_regs.sv
// aes_wb_regs: Wishbone B4 classic slave holding the AES control, key and
// text registers, and sequencing the start/result handshake of aes_core.
module aes_wb_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned BUSY_LIMIT = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic         core_rst_n_o,
    output logic         core_ld_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_text_o,
    input  logic         core_done_i,
    input  logic [127:0] core_text_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             ack_q;
    logic             served_q;
    logic [31:0]      dat_q;
    logic             en_q;
    logic             start_q;
    logic             done_q;
    logic             tout_q;
    logic [3:0][31:0] key_q;
    logic [3:0][31:0] txt_q;
    logic [7:0]       cnt_q;
    logic             go_q;
    logic             ld_q;

    logic             hit;
    logic             ack_d;
    logic             wr;
    logic [7:0]       off;
    logic             is_ctrl;
    logic             is_key;
    logic             is_txt;
    logic [1:0]       key_idx;
    logic [1:0]       txt_idx;
    logic [31:0]      rdata;
    logic [31:0]      dat_d;
    logic             start_req;
    logic             disable_req;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode, read mux and request qualification
    always_comb begin
        off         = wbs_adr_i[7:0];
        hit         = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        is_ctrl     = hit && (off == 8'h00);
        is_key      = hit && (off inside {8'h04, 8'h08, 8'h0C, 8'h10});
        is_txt      = hit && (off inside {8'h14, 8'h18, 8'h1C, 8'h20});
        key_idx     = 2'((off - 8'h04) >> 2);
        txt_idx     = 2'((off - 8'h14) >> 2);
        ack_d       = wbs_stb_i & wbs_cyc_i & ~ack_q & ~served_q;
        wr          = ack_d & wbs_we_i;
        rdata       = '0;
        if (is_ctrl)     rdata = {28'd0, tout_q, done_q, start_q, en_q};
        else if (is_key) rdata = key_q[key_idx];
        else if (is_txt) rdata = txt_q[txt_idx];
        dat_d       = (ack_d & ~wbs_we_i) ? rdata : '0;
        disable_req = wr & is_ctrl & wbs_sel_i[0] & ~wbs_dat_i[0];
        start_req   = wr & is_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & wbs_dat_i[1]
                      & ~start_q & (state_q != S_BUSY);
    end

    // Bus handshake: single-cycle ack, registered read data, one ack per strobe
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            served_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            if (!wbs_stb_i)  served_q <= 1'b0;
            else if (ack_d)  served_q <= 1'b1;
        end
    end

    // Key registers, frozen while the core is running
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            key_q <= '0;
        end else if (wr && is_key && (state_q != S_BUSY)) begin
            key_q[key_idx] <= merge(key_q[key_idx], wbs_dat_i, wbs_sel_i);
        end
    end

    // Control FSM: CTRL bits, text registers, start pulse and busy timeout
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            txt_q   <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            ld_q <= go_q;
            go_q <= 1'b0;

            if (wr && is_txt && (state_q != S_BUSY)) begin
                txt_q[txt_idx] <= merge(txt_q[txt_idx], wbs_dat_i, wbs_sel_i);
            end

            // done is ignored until the ld pulse has gone out, so a level-style
            // done left over from the previous run cannot complete the new one
            if (state_q == S_BUSY) begin
                if (core_done_i && !go_q && !ld_q) begin
                    txt_q   <= core_text_i;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else if (cnt_q == 8'(BUSY_LIMIT)) begin
                    tout_q  <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end

            if (wr && is_ctrl && wbs_sel_i[0]) begin
                en_q    <= wbs_dat_i[0];
                start_q <= wbs_dat_i[1];
            end

            if (disable_req) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
                tout_q  <= 1'b0;
                go_q    <= 1'b0;
            end else if (start_req) begin
                state_q <= S_BUSY;
                done_q  <= 1'b0;
                tout_q  <= 1'b0;
                cnt_q   <= '0;
                go_q    <= 1'b1;
            end
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign core_rst_n_o = en_q;
    assign core_ld_o    = ld_q;
    assign core_key_o   = key_q;
    assign core_text_o  = txt_q;

endmodule

// File: tb/tb_aes_wb_regs.sv
// tb_aes_wb_regs: scoreboard-based bench for aes_wb_regs with a simple
// core model that returns a fixed ciphertext 20 cycles after the ld pulse.
module tb_aes_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk;
    logic         rst;
    logic         stb;
    logic         cyc;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  dati;
    logic [31:0]  adr;
    logic         ack;
    logic [31:0]  dato;
    logic         core_rst_n;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_res;

    int           n_checks;
    int           n_fail;
    int           ack_cnt;
    int           ld_cnt;
    logic         core_en;
    logic [127:0] key_seen;
    logic [127:0] txt_seen;
    logic [31:0]  exp_q[$];

    logic [127:0] key_v;
    logic [127:0] pt_v;
    logic [127:0] ct_v;

    aes_wb_regs #(.BASE_ADDR(32'h3000_0000), .BUSY_LIMIT(255)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (dati),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dato),
        .core_rst_n_o (core_rst_n),
        .core_ld_o    (core_ld),
        .core_key_o   (core_key),
        .core_text_o  (core_text),
        .core_done_i  (core_done),
        .core_text_i  (core_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack === 1'b1)     ack_cnt <= ack_cnt + 1;
        if (core_ld === 1'b1) ld_cnt  <= ld_cnt + 1;
    end

    // Core model: on ld, record what it was given and answer 20 cycles later
    initial begin
        core_done = 1'b0;
        core_res  = '0;
        key_seen  = '0;
        txt_seen  = '0;
        forever begin
            @(negedge clk);
            if (core_ld === 1'b1 && core_en) begin
                key_seen = core_key;
                txt_seen = core_text;
                repeat (20) @(negedge clk);
                core_done = 1'b1;
                core_res  = ct_v;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dati = d; sel = s;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                rd  = dato;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout adr=%h: got no ack within 16 cycles, required one", a);
        end
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused;
        bus(1'b1, a, d, 4'hF, unused);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        int          base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, dato, core_ld, core_rst_n} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b dat=%h ld=%b rst_n=%b, required all 0",
                     ack, dato, core_ld, core_rst_n);
        end
        n_checks++;
        if ({core_key, core_text} !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_core_bus: key=%h text=%h, required 0", core_key, core_text);
        end
        rst = 1'b0;
        @(negedge clk);
        base = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(32'h0);
            bus(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL reset_read off=%h: got %h, required %h", 4 * i, rd, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ack_cnt - base !== 9) begin
            n_fail++;
            $display("FAIL reset_ack_count: got %0d acks, required 9", ack_cnt - base);
        end
        n_checks++;
        if (dato !== 32'h0) begin
            n_fail++;
            $display("FAIL dat_idle: got %h with ack low, required 0", dato);
        end
    endtask

    task automatic test_rw();
        logic [31:0] rd;
        logic [31:0] exp;
        for (int i = 1; i <= 8; i++) wr32(BASE + 32'(4 * i), 32'hFFFF_FFFF);
        wr32(BASE, 32'h3);
        for (int i = 0; i <= 8; i++) begin
            exp_q.push_back(i == 0 ? 32'h3 : 32'hFFFF_FFFF);
            bus(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL rw_readback off=%h: got %h, required %h", 4 * i, rd, exp);
            end
        end
        wr32(BASE, 32'h0);
    endtask

    task automatic test_hold();
        int base;
        @(negedge clk);
        base = ack_cnt;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h4; dati = 32'h1111_1111; sel = 4'hF;
        repeat (6) @(negedge clk);
        n_checks++;
        if (ack_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL hold_single_ack: got %0d acks over 6 cycles, required 1", ack_cnt - base);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        @(negedge clk);
        exp_q.push_back(32'h1111_1111);
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h4;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_next_ack: ack=%b one cycle after stb, required 1", ack);
        end
        n_checks++;
        if (dato !== exp_q[0]) begin
            n_fail++;
            $display("FAIL hold_next_data: got %h, required %h", dato, exp_q[0]);
        end
        void'(exp_q.pop_front());
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic test_aes();
        logic [31:0] rd;
        logic [31:0] exp;
        int          base;
        core_en = 1'b1;
        base    = ld_cnt;
        for (int i = 0; i < 4; i++) wr32(BASE + 32'(4 + 4 * i), key_v[32 * i +: 32]);
        for (int i = 0; i < 4; i++) wr32(BASE + 32'(20 + 4 * i), pt_v[32 * i +: 32]);
        wr32(BASE, 32'h1);
        wr32(BASE, 32'h3);
        wr32(BASE, 32'h1);
        repeat (40) @(negedge clk);
        n_checks++;
        if (ld_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL aes_ld_pulses: got %0d, required 1", ld_cnt - base);
        end
        n_checks++;
        if (key_seen !== key_v) begin
            n_fail++;
            $display("FAIL aes_core_key: got %h, required %h", key_seen, key_v);
        end
        n_checks++;
        if (txt_seen !== pt_v) begin
            n_fail++;
            $display("FAIL aes_core_text: got %h, required %h", txt_seen, pt_v);
        end
        exp_q.push_back(32'h5);
        bus(1'b0, BASE, 32'h0, 4'h0, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL aes_ctrl: got %h, required %h", rd, exp);
        end
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(ct_v[32 * i +: 32]);
            bus(1'b0, BASE + 32'(20 + 4 * i), 32'h0, 4'h0, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL aes_result TXT%0d: got %h, required %h", i + 1, rd, exp);
            end
        end
        core_en = 1'b0;
    endtask

    task automatic test_busy();
        logic [31:0] rd;
        logic [31:0] exp;
        wr32(BASE, 32'h3);
        wr32(BASE, 32'h1);
        exp_q.push_back(32'h1);
        bus(1'b0, BASE, 32'h0, 4'h0, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL busy_ctrl: got %h, required %h", rd, exp);
        end
        wr32(BASE + 32'h14, 32'h1234_5678);
        exp_q.push_back(32'ha6c3_2e90);
        bus(1'b0, BASE + 32'h14, 32'h0, 4'h0, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL busy_txt_locked: got %h, required %h", rd, exp);
        end
        repeat (300) @(negedge clk);
        exp_q.push_back(32'h9);
        bus(1'b0, BASE, 32'h0, 4'h0, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL busy_timeout_ctrl: got %h, required %h", rd, exp);
        end
        exp_q.push_back(32'ha6c3_2e90);
        bus(1'b0, BASE + 32'h14, 32'h0, 4'h0, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL timeout_txt_kept: got %h, required %h", rd, exp);
        end
    endtask

    task automatic test_sel_and_decode();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] addrs[4];
        logic [31:0] exps[4];
        wr32(BASE, 32'h0);
        wr32(BASE + 32'h4, 32'h0);
        bus(1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0010, rd);
        wr32(BASE + 32'h24, 32'hFFFF_FFFF);
        wr32(32'h4000_0004, 32'hFFFF_FFFF);
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h24, 32'h4000_0004};
        exps  = '{32'h0, 32'h0000_CC00, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            bus(1'b0, addrs[i], 32'h0, 4'h0, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL decode_read adr=%h: got %h, required %h", addrs[i], rd, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ack_cnt  = 0;
        ld_cnt   = 0;
        core_en  = 1'b0;
        key_v    = 128'h4f2f8b71_e8c5340f_0b21fd95_af7fe629;
        pt_v     = 128'h436f620f_120bce3c_d275a91d_f918d31d;
        ct_v     = 128'haaaa9250_3215c96b_b93e66d7_a6c32e90;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dati = '0; adr = '0;
        test_reset();
        test_rw();
        test_hold();
        test_aes();
        test_busy();
        test_sel_and_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
